// File: rtl/bus_req_sequencer_if.sv
// Command, subsystem-bus and response signal bundle for bus_req_sequencer.
// master = the sequencer, slave = the environment (command source, target, response sink).
interface bus_req_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] bus_wdata;
    logic                  bus_wen;
    logic                  bus_ren;
    logic [DATA_WIDTH-1:0] bus_rdata;
    logic                  bus_valid;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_error;
    logic [7:0]            err_count;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, bus_rdata, bus_valid, rsp_ready,
        output req_ready, bus_addr, bus_wdata, bus_wen, bus_ren,
        output rsp_valid, rsp_rdata, rsp_error, err_count
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, bus_rdata, bus_valid, rsp_ready,
        input  req_ready, bus_addr, bus_wdata, bus_wen, bus_ren,
        input  rsp_valid, rsp_rdata, rsp_error, err_count
    );
endinterface

// File: rtl/bus_req_sequencer.sv
// Single-outstanding read/write sequencer: posted writes, reads with bus_valid
// wait and timeout, read data returned on a valid/ready response stream.
module bus_req_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bus_req_sequencer_if.master   bus
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_write;
    logic                  r_req_ready;
    logic [ADDR_WIDTH-1:0] r_bus_addr;
    logic [DATA_WIDTH-1:0] r_bus_wdata;
    logic                  r_bus_wen;
    logic                  r_bus_ren;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_error;
    logic [7:0]            r_err_count;
    logic                  w_req_fire;

    assign w_req_fire = bus.req_valid && r_req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_write     <= 1'b0;
            r_req_ready <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_wen   <= 1'b0;
            r_bus_ren   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_bus_wen <= 1'b0;
            r_bus_ren <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Strobes are registered on entry so they are visible during ISSUE.
                    if (w_req_fire) begin
                        r_bus_addr  <= bus.req_addr;
                        r_bus_wdata <= bus.req_wdata;
                        r_write     <= bus.req_write;
                        r_bus_wen   <= bus.req_write;
                        r_bus_ren   <= !bus.req_write;
                        r_req_ready <= 1'b0;
                        r_state     <= S_ISSUE;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (r_write) begin
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.bus_valid) begin
                        r_rsp_rdata <= bus.bus_rdata;
                        r_rsp_error <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (r_cnt == CNT_LAST) begin
                        r_rsp_rdata <= '0;
                        r_rsp_error <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        if (r_err_count != '1) r_err_count <= r_err_count + 8'd1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.bus_addr  = r_bus_addr;
    assign bus.bus_wdata = r_bus_wdata;
    assign bus.bus_wen   = r_bus_wen;
    assign bus.bus_ren   = r_bus_ren;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_error = r_rsp_error;
    assign bus.err_count = r_err_count;
endmodule

// File: tb/tb_bus_req_sequencer.sv
// Scoreboard bench for bus_req_sequencer: expected read responses are queued
// at issue and popped when the response handshake happens.
module tb_bus_req_sequencer;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int TO = 8;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          error;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   err_exp  = 0;
    exp_t sb_q[$];

    bus_req_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bif ();

    bus_req_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && !bif.req_ready; i++) @(negedge clk);
        check_eq("req_ready_wait", bif.req_ready, 1);
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        wait_ready();
        bif.req_valid = 1'b1; bif.req_write = 1'b1;
        bif.req_addr = addr;  bif.req_wdata = data;
        @(negedge clk);
        bif.req_valid = 1'b0;
        check_eq("wr_wen", bif.bus_wen, 1);
        check_eq("wr_ren", bif.bus_ren, 0);
        check_eq("wr_addr", bif.bus_addr, addr);
        check_eq("wr_wdata", bif.bus_wdata, data);
        check_eq("wr_rdy_low", bif.req_ready, 0);
        @(negedge clk);
        check_eq("wr_rdy_back", bif.req_ready, 1);
        check_eq("wr_wen_off", bif.bus_wen, 0);
        check_eq("wr_no_rsp", bif.rsp_valid, 0);
    endtask

    // lat = WAIT cycle (1-based) carrying bus_valid, 0 = never (timeout).
    task automatic do_read(input logic [AW-1:0] addr, input int lat, input logic [DW-1:0] data,
                           input int hold, input bit stray);
        exp_t e;
        exp_t got_e;
        int   cyc;
        bit   got;
        logic [DW-1:0] snap;
        wait_ready();
        bif.req_valid = 1'b1; bif.req_write = 1'b0;
        bif.req_addr = addr;  bif.req_wdata = $urandom;
        e.rdata = (lat != 0) ? data : '0;
        e.error = (lat == 0);
        sb_q.push_back(e);
        if (stray) begin bif.bus_valid = 1'b1; bif.bus_rdata = '1; end
        @(negedge clk);
        cyc = 1;
        bif.req_valid = 1'b0;
        check_eq("rd_ren", bif.bus_ren, 1);
        check_eq("rd_wen", bif.bus_wen, 0);
        check_eq("rd_addr", bif.bus_addr, addr);
        got = 0;
        while (!got && cyc < 40) begin
            if (cyc >= 2) begin
                bif.bus_valid = (lat != 0 && cyc == lat + 1);
                bif.bus_rdata = bif.bus_valid ? data : $urandom;
            end
            @(negedge clk);
            cyc++;
            if (bif.rsp_valid) got = 1;
        end
        bif.bus_valid = 1'b0;
        check_eq("rsp_seen", got, 1);
        if (got) begin
            check_eq("rsp_cycle", cyc, (lat != 0) ? lat + 2 : TO + 2);
            if (hold > 0) begin
                bif.rsp_ready = 1'b0;
                for (int i = 0; i < hold; i++) begin
                    snap = bif.rsp_rdata;
                    bif.req_valid = 1'b1; bif.req_write = 1'b1;
                    @(negedge clk);
                    bif.req_valid = 1'b0;
                    check_eq("bp_valid", bif.rsp_valid, 1);
                    check_eq("bp_rdata", bif.rsp_rdata, snap);
                    check_eq("bp_rdy", bif.req_ready, 0);
                    check_eq("bp_no_wen", bif.bus_wen, 0);
                end
                bif.rsp_ready = 1'b1;
            end
            check_eq("sb_nonempty", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
                got_e = sb_q.pop_front();
                check_eq("rsp_rdata", bif.rsp_rdata, got_e.rdata);
                check_eq("rsp_error", bif.rsp_error, got_e.error);
            end
            if (lat == 0 && err_exp < 255) err_exp++;
            check_eq("err_count", bif.err_count, err_exp);
            @(negedge clk);
            check_eq("rsp_done", bif.rsp_valid, 0);
            check_eq("rdy_after_rsp", bif.req_ready, 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst_n = 1'b0;
        bif.req_valid = 1'b0; bif.req_write = 1'b0; bif.req_addr = '0; bif.req_wdata = '0;
        bif.bus_rdata = '0;   bif.bus_valid = 1'b0; bif.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", bif.req_ready, 0);
        check_eq("rst_rsp", bif.rsp_valid, 0);
        check_eq("rst_err", bif.err_count, 0);
        rst_n = 1'b1;
        check_eq("rel_ready", bif.req_ready, 0);
        @(negedge clk);
        check_eq("rel_ready_edge", bif.req_ready, 1);

        do_write(16'h0010, 32'hDEADBEEF);
        repeat (3) @(negedge clk);
        check_eq("wr_no_rsp_late", bif.rsp_valid, 0);

        do_read(16'h0010, 1, 32'hDEADBEEF, 0, 1'b0);
        do_read(16'h8000, 0, '0, 0, 1'b0);
        do_read(16'h0020, 5, 32'h12345678, 0, 1'b0);
        do_read(16'h0030, 1, 32'hA5A5_0001, 5, 1'b0);
        do_read(16'h0040, 2, 32'h0BAD_CAFE, 0, 1'b1);

        // Stray bus_valid while idle must not create a response
        bif.bus_valid = 1'b1; bif.bus_rdata = 32'hFFFF_0000;
        seen = 0;
        repeat (4) begin @(negedge clk); seen |= bif.rsp_valid; end
        bif.bus_valid = 1'b0;
        check_eq("stray_idle", seen, 0);

        for (int i = 0; i < 255; i++) do_read(16'h8000 + 16'(i), 0, '0, 0, 1'b0);
        check_eq("err_sat", bif.err_count, 255);

        do_write(16'h0100, 32'h0000_1111);

        // Reset in the middle of WAIT
        wait_ready();
        bif.req_valid = 1'b1; bif.req_write = 1'b0; bif.req_addr = 16'h9000;
        @(negedge clk);
        bif.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_ready", bif.req_ready, 0);
        check_eq("mid_ren", bif.bus_ren, 0);
        check_eq("mid_addr", bif.bus_addr, 0);
        check_eq("mid_wdata", bif.bus_wdata, 0);
        check_eq("mid_rsp", bif.rsp_valid, 0);
        check_eq("mid_rerr", bif.rsp_error, 0);
        check_eq("mid_err", bif.err_count, 0);
        err_exp = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_ready", bif.req_ready, 1);
        seen = 0;
        repeat (12) begin @(negedge clk); seen |= bif.rsp_valid; end
        check_eq("post_rst_no_rsp", seen, 0);
        do_read(16'h0010, 1, 32'hCAFE_F00D, 0, 1'b0);
        do_read(16'h8001, 0, '0, 0, 1'b0);

        check_eq("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_req_sequencer.md
Name: bus_req_sequencer

Overview:
Single-outstanding request sequencer that sits directly upstream of the address-decoded memory/FIFO subsystem top. It accepts read/write commands on a valid/ready stream and drives the subsystem's addr/wdata/wen/ren strobes. For reads, it waits for the subsystem's valid pulse, or times out for unmapped regions, and returns the read data on a valid/ready response stream. Writes are posted and return no response.

Parameters:
DATA_WIDTH, 32, width of write/read data
ADDR_WIDTH, 16, width of request/bus address
TIMEOUT, 8, max WAIT cycles for bus_valid before error (legal range 2..255)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  command valid
req_ready  output  1  command accepted when high together with req_valid
req_write  input  1  1=write, 0=read
req_addr  input  ADDR_WIDTH  command address
req_wdata  input  DATA_WIDTH  write data
bus_addr  output  ADDR_WIDTH  address to subsystem
bus_wdata  output  DATA_WIDTH  write data to subsystem
bus_wen  output  1  one-cycle write strobe
bus_ren  output  1  one-cycle read strobe
bus_rdata  input  DATA_WIDTH  subsystem read data
bus_valid  input  1  subsystem read-data valid
rsp_valid  output  1  read response valid
rsp_ready  input  1  response consumer ready
rsp_rdata  output  DATA_WIDTH  read data (0 on error)
rsp_error  output  1  1 = read timed out
err_count  output  8  saturating count of timeouts

Behaviour:
- Interface decision: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, timeout counter 0. req_ready rises on the first clk edge after rst_n deasserts.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE:
  - req_ready=1.
  - Handshake when req_valid && req_ready: latch req_addr/req_wdata/req_write into bus_addr/bus_wdata/write flag, clear req_ready, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - bus_wen=write flag, bus_ren=!write flag.
  - Write: go to IDLE; req_ready=1 the next cycle.
  - Read: go to WAIT with counter=0.
- bus_addr/bus_wdata hold their latched values until the next accepted command.
- WAIT:
  - bus_valid=1: capture bus_rdata into rsp_rdata, rsp_error=0, go to RESP.
  - bus_valid=0 and counter==TIMEOUT-1: rsp_rdata=0, rsp_error=1, err_count+=1 (saturating at 255), go to RESP.
  - Otherwise counter+=1.
- RESP:
  - rsp_valid=1; rsp_rdata/rsp_error stay stable while rsp_ready=0.
  - On rsp_valid && rsp_ready: clear rsp_valid, go to IDLE, req_ready=1 the next cycle.
- bus_valid is sampled only in WAIT and ignored in every other state.
- Only one command is in flight at a time. req_valid is ignored while req_ready=0.
- Read latency with a 1-cycle target: handshake in cycle 0, bus_ren in cycle 1, bus_valid in cycle 2, rsp_valid in cycle 3. This gives a read issue rate of at most 1 per 4 cycles.
- Timeout read: rsp_valid in cycle TIMEOUT+2 after the handshake cycle.
- Write issue rate: at most 1 per 2 cycles.
- Reset mid-operation:
  - All in-flight state is dropped immediately.
  - Pending strobe and response are lost; no response is generated after release.
  - err_count resets to 0.
- Width rules:
  - Counter width is $clog2(TIMEOUT).
  - err_count never wraps.

Test Plan:
- Write: req_write=1, addr=0x0010, wdata=0xDEADBEEF handshaked in cycle 0 -> cycle 1 bus_wen=1, bus_ren=0, bus_addr=0x0010, bus_wdata=0xDEADBEEF; cycle 2 req_ready=1; rsp_valid never asserts.
- Read hit: read addr=0x0010; target drives bus_valid=1, bus_rdata=0xDEADBEEF in cycle 2 -> cycle 1 bus_ren=1 only; cycle 3 rsp_valid=1, rsp_rdata=0xDEADBEEF, rsp_error=0.
- Timeout: read addr=0x8000, bus_valid held 0 -> rsp_valid in cycle 10 with rsp_rdata=0, rsp_error=1, err_count=1. A 256th consecutive timeout leaves err_count=255.
- Backpressure and stray valid:
  - rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_rdata held stable, req_ready=0, req_valid pulses not accepted.
  - rsp_ready=1 -> IDLE, req_ready=1 the next cycle.
  - A bus_valid pulse in IDLE or ISSUE produces no response.
- Late response: bus_valid first arrives in the 5th WAIT cycle with rdata=0x12345678 -> rsp_valid the next cycle, rsp_rdata=0x12345678, rsp_error=0, err_count unchanged.
- Reset mid-read: rst_n pulled low during WAIT -> all outputs 0 asynchronously, before the next edge. After release: req_ready=1 after the first edge, no rsp_valid, and a new read completes normally.
